// File: rtl/ram_seq_scanner_pkg.sv
// ============================================================================
// Module  : ram_seq_scanner_pkg
// Purpose : Shared state encodings and default widths for ram_seq_scanner.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_seq_scanner_pkg;

    localparam int C_RAM_WIDTH = 8;
    localparam int C_ADDR_SIZE = 5;
    localparam int C_COUNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        FIN   = 3'd4
    } scan_state_t;

    typedef enum logic [1:0] {
        D0  = 2'd0,
        D1  = 2'd1,
        D2  = 2'd2,
        HIT = 2'd3
    } det_state_t;

endpackage

`default_nettype wire

// File: rtl/seq001_bit_detector.sv
// ============================================================================
// Module  : seq001_bit_detector
// Purpose : Overlapping "001" detector; hit is a registered one-cycle pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq001_bit_detector
    import ram_seq_scanner_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic hit,
    output logic hit_next
);

    det_state_t r_state;
    det_state_t w_next;

    always_comb begin
        w_next = r_state;
        if (bit_valid) begin
            case (r_state)
                D0:      w_next = bit_in ? D0  : D1;
                D1:      w_next = bit_in ? D0  : D2;
                D2:      w_next = bit_in ? HIT : D2;
                HIT:     w_next = bit_in ? D0  : D1;
                default: w_next = D0;
            endcase
        end
    end

    // Qualified by bit_valid so a HIT state parked between words never re-fires.
    assign hit_next = bit_valid && (w_next == HIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= D0;
            hit     <= 1'b0;
        end else if (clr) begin
            r_state <= D0;
            hit     <= 1'b0;
        end else begin
            r_state <= w_next;
            hit     <= hit_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_seq_scanner.sv
// ============================================================================
// Module  : ram_seq_scanner
// Purpose : Sweeps a RAM address window, serialises each word MSB-first into
//           a "001" detector and reports matches. Option macro:
//           SCAN_STOP_ON_MATCH_EN (finish the scan on the first match).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_seq_scanner
    import ram_seq_scanner_pkg::*;
#(
    parameter int RAM_WIDTH = C_RAM_WIDTH,
    parameter int ADDR_SIZE = C_ADDR_SIZE,
    parameter int COUNT_W   = C_COUNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [ADDR_SIZE-1:0] end_addr,
    output logic                 en_read,
    output logic [ADDR_SIZE-1:0] addr,
    input  logic [RAM_WIDTH-1:0] data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 sequence_found,
    output logic [COUNT_W-1:0]   match_count,
    output logic [ADDR_SIZE-1:0] last_match_addr
);

    localparam int                 C_BCNT_W   = (RAM_WIDTH > 1) ? $clog2(RAM_WIDTH) : 1;
    localparam logic [C_BCNT_W-1:0] C_LAST_BIT = C_BCNT_W'(RAM_WIDTH - 1);

    scan_state_t          r_state;
    scan_state_t          w_next;
    logic [ADDR_SIZE-1:0] r_cur;
    logic [ADDR_SIZE-1:0] r_end;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [RAM_WIDTH-1:0] r_shreg;
    logic [C_BCNT_W-1:0]  r_bitcnt;
    logic [COUNT_W-1:0]   r_count;
    logic [ADDR_SIZE-1:0] r_last;

    logic w_accept;
    logic w_last_bit;
    logic w_advance;
    logic w_det_hit;
    logic w_det_hit_next;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_last_bit = (r_state == SHIFT) && (r_bitcnt == C_LAST_BIT);
    assign w_advance  = w_last_bit && (w_next == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = REQ;
            REQ:     w_next = WAIT;
            WAIT:    w_next = SHIFT;
            SHIFT:   if (w_last_bit) w_next = (r_cur == r_end) ? FIN : REQ;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
`ifdef SCAN_STOP_ON_MATCH_EN
        if (w_det_hit && (r_state inside {REQ, WAIT, SHIFT})) begin
            w_next = FIN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur    <= '0;
            r_end    <= '0;
            r_addr   <= '0;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_accept) begin
                r_cur   <= start_addr;
                r_end   <= end_addr;
                r_addr  <= start_addr;
                r_count <= '0;
                r_last  <= '0;
            end
            if (r_state == WAIT) begin
                r_shreg  <= data_out;
                r_bitcnt <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg  <= r_shreg << 1;
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            // Wraps naturally through the top of the address space.
            if (w_advance) begin
                r_cur  <= r_cur + 1'b1;
                r_addr <= r_cur + 1'b1;
            end
            // Recorded with the word that is still being shifted, before any advance.
            if (w_det_hit_next) begin
                if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
                r_last <= r_cur;
            end
        end
    end

    seq001_bit_detector u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_accept),
        .bit_valid (r_state == SHIFT),
        .bit_in    (r_shreg[RAM_WIDTH-1]),
        .hit       (w_det_hit),
        .hit_next  (w_det_hit_next)
    );

    assign en_read         = (r_state == REQ);
    assign addr            = r_addr;
    assign busy            = (r_state inside {REQ, WAIT, SHIFT});
    assign done            = (r_state == FIN);
    assign sequence_found  = w_det_hit;
    assign match_count     = r_count;
    assign last_match_addr = r_last;

endmodule

`default_nettype wire

// File: tb/tb_ram_seq_scanner.sv
// ============================================================================
// Module  : tb_ram_seq_scanner
// Purpose : Scoreboard bench for ram_seq_scanner with a registered-read RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_seq_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] start_addr;
    logic [4:0] end_addr;
    logic       en_read;
    logic [4:0] addr;
    logic [7:0] data_out = 8'h00;
    logic       busy;
    logic       done;
    logic       sequence_found;
    logic [15:0] match_count;
    logic [4:0] last_match_addr;

    logic [7:0] mem [0:31];

    typedef struct {
        int cyc;
        int cnt;
        int la;
    } ev_t;

    int   exp_addr [$];
    ev_t  exp_hit  [$];
    ev_t  exp_done [$];

    int cyc = 0;
    int t0  = 0;
    int vectors = 0;
    int miscompares = 0;

    ram_seq_scanner dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_addr      (start_addr),
        .end_addr        (end_addr),
        .en_read         (en_read),
        .addr            (addr),
        .data_out        (data_out),
        .busy            (busy),
        .done            (done),
        .sequence_found  (sequence_found),
        .match_count     (match_count),
        .last_match_addr (last_match_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en_read) data_out <= mem[addr];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d after start)", name, got, want, cyc - t0);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a read, a match or done.
    initial begin
        int  a;
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (en_read) begin
                    if (exp_addr.size() == 0) begin
                        check("unexpected_read", 1, 0);
                    end else begin
                        a = exp_addr.pop_front();
                        check("read_addr", addr, a);
                    end
                end
                if (sequence_found) begin
                    if (exp_hit.size() == 0) begin
                        check("unexpected_match", 1, 0);
                    end else begin
                        e = exp_hit.pop_front();
                        check("match_cycle", cyc - t0, e.cyc - t0);
                        check("match_count_at_match", match_count, e.cnt);
                        check("last_addr_at_match", last_match_addr, e.la);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_cycle", cyc - t0, e.cyc - t0);
                        check("match_count_at_done", match_count, e.cnt);
                        check("last_addr_at_done", last_match_addr, e.la);
                    end
                end
            end
        end
    end

    task automatic push_addr(input int a);
        exp_addr.push_back(a);
    endtask

    task automatic push_hit(input int rel, input int cnt, input int la);
        ev_t e;
        e.cyc = t0 + rel; e.cnt = cnt; e.la = la;
        exp_hit.push_back(e);
    endtask

    task automatic push_done(input int rel, input int cnt, input int la);
        ev_t e;
        e.cyc = t0 + rel; e.cnt = cnt; e.la = la;
        exp_done.push_back(e);
    endtask

    // Leaves the bench at the negedge of cycle 0 so expectations can be pushed.
    task automatic begin_scan(input logic [4:0] sa, input logic [4:0] ea);
        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        end_addr   = ea;
        t0         = cyc;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - t0 < rel) @(negedge clk);
    endtask

    task automatic drain();
        check("pending_reads", exp_addr.size(), 0);
        check("pending_matches", exp_hit.size(), 0);
        check("pending_dones", exp_done.size(), 0);
        exp_addr.delete();
        exp_hit.delete();
        exp_done.delete();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {en_read, addr, busy, done, sequence_found, match_count, last_match_addr}, 0);
    endtask

    task automatic fill_identity();
        for (int k = 0; k < 32; k++) mem[k] = 8'(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        for (int k = 0; k < 32; k++) mem[k] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef SCAN_STOP_ON_MATCH_EN
        // Identity contents, window 0..1: only the LSB of word 1 completes a match.
        fill_identity();
        begin_scan(5'd0, 5'd1);
        push_addr(0); push_addr(1);
        push_hit(21, 1, 1);
        push_done(21, 1, 1);
        release_start();
        wait_rel(26);
        drain();
        check("hold_count_after_done", match_count, 1);
        check("hold_last_after_done", last_match_addr, 1);

        // One match per word at shift index 5.
        begin_scan(5'd4, 5'd5);
        push_addr(4); push_addr(5);
        push_hit(9, 1, 4);
        push_hit(19, 2, 5);
        push_done(21, 2, 5);
        release_start();
        wait_rel(26);
        drain();

        // Detector state carries across the word boundary.
        mem[0] = 8'h80; mem[1] = 8'h80;
        begin_scan(5'd0, 5'd1);
        push_addr(0); push_addr(1);
        push_hit(14, 1, 1);
        push_done(21, 1, 1);
        release_start();
        wait_rel(26);
        drain();

        // Window wraps from 31 to 0.
        mem[31] = 8'h00; mem[0] = 8'h40;
        begin_scan(5'd31, 5'd0);
        push_addr(31); push_addr(0);
        push_hit(15, 1, 0);
        push_done(21, 1, 0);
        release_start();
        wait_rel(26);
        drain();

        // Ignored restart while busy, then reset in the middle of word 3.
        fill_identity();
        begin_scan(5'd0, 5'd5);
        push_addr(0); push_addr(1); push_addr(2); push_addr(3);
        push_hit(21, 1, 1);
        push_hit(30, 2, 2);
        release_start();
        wait_rel(5);
        start = 1'b1; start_addr = 5'd10; end_addr = 5'd10;
        @(negedge clk);
        start = 1'b0;
        wait_rel(35);
        check("busy_before_abort", busy, 1);
        check("count_before_abort", match_count, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        repeat (3) @(negedge clk);
        check_all_zero("held_reset_outputs");
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("no_done_after_abort", done, 0);
        drain();

        // Restart after reset counts from zero.
        begin_scan(5'd2, 5'd2);
        push_addr(2);
        push_hit(10, 1, 2);
        push_done(11, 1, 2);
        release_start();
        wait_rel(16);
        drain();
        check("restart_final_count", match_count, 1);
`else
        // First match ends the scan on the following cycle.
        fill_identity();
        begin_scan(5'd0, 5'd31);
        push_addr(0); push_addr(1); push_addr(2);
        push_hit(21, 1, 1);
        push_done(22, 1, 1);
        release_start();
        wait_rel(40);
        drain();
        check("stop_final_count", match_count, 1);
        check("stop_final_last", last_match_addr, 1);
        check("stop_idle_busy", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
